// File: rtl/usr_seq_ctrl.sv
// rtl/usr_seq_ctrl.sv - command sequencer driving a 4-bit universal shift register
// Accepts load/shift/rotate commands and steps the external register one mode per cycle.
module usr_seq_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_data,
  input  logic [2:0] cmd_cnt,
  input  logic       cmd_fill,
  output logic [1:0] usr_s,
  output logic       usr_s_r_in,
  output logic       usr_s_l_in,
  output logic [3:0] usr_p_in,
  input  logic [3:0] usr_q,
  output logic       ser_out,
  output logic       ser_out_valid,
  output logic       busy,
  output logic       done,
  output logic [3:0] result
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHR  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_ROR  = 2'b11;

  logic [1:0] r_state;
  logic [1:0] r_op;
  logic [3:0] r_data;
  logic       r_fill;
  logic [2:0] r_cnt;
  logic [3:0] r_result;

  logic       w_accept;
  logic [2:0] w_cnt_clamped;

  assign w_accept      = cmd_valid && (r_state == ST_IDLE);
  assign w_cnt_clamped = (cmd_cnt > 3'd4) ? 3'd4 : cmd_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_op     <= 2'b00;
      r_data   <= 4'b0000;
      r_fill   <= 1'b0;
      r_cnt    <= 3'd0;
      r_result <= 4'b0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op   <= cmd_op;
            r_data <= cmd_data;
            r_fill <= cmd_fill;
            r_cnt  <= w_cnt_clamped;
            if (cmd_op == OP_LOAD)
              r_state <= ST_LOAD;
            else if (w_cnt_clamped != 3'd0)
              r_state <= ST_SHIFT;
            else
              r_state <= ST_DONE;
          end
        end
        ST_LOAD: r_state <= ST_DONE;
        ST_SHIFT: begin
          // r_cnt holds the steps still to issue, including this cycle's
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt <= 3'd1)
            r_state <= ST_DONE;
        end
        default: begin
          r_result <= usr_q;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    usr_s         = 2'b00;
    usr_s_r_in    = 1'b0;
    usr_s_l_in    = 1'b0;
    usr_p_in      = 4'b0000;
    ser_out       = 1'b0;
    ser_out_valid = 1'b0;
    case (r_state)
      ST_LOAD: begin
        usr_s    = 2'b11;
        usr_p_in = r_data;
      end
      ST_SHIFT: begin
        ser_out_valid = 1'b1;
        case (r_op)
          OP_SHL: begin
            usr_s      = 2'b10;
            usr_s_l_in = r_fill;
            ser_out    = usr_q[3];
          end
          OP_ROR: begin
            usr_s      = 2'b01;
            usr_s_r_in = usr_q[0];
            ser_out    = usr_q[0];
          end
          default: begin
            usr_s      = 2'b01;
            usr_s_r_in = r_fill;
            ser_out    = usr_q[0];
          end
        endcase
      end
      default: ;
    endcase
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign result    = (r_state == ST_DONE) ? usr_q : r_result;

endmodule
